counter_seq_ctrl: RTL

- Sequencing controller for a WIDTH-bit loadable up/down counter.
- Starts, pauses, stops and reloads the count, detects terminal count and signals completion.
- Supports one-shot and auto-reload modes.
- Sits between the software/control layer and the counter datapath in the embedded experiment designs.

---
 rtl/counter_seq_pkg.sv | 14 +
 rtl/counter_seq_ctrl_core.sv | 29 ++
 rtl/counter_seq_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared state and direction encodings for the counter sequencer
package counter_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_seq_ctrl_core.sv
// rtl/counter_seq_ctrl_core.sv - loadable up/down count register, clear > load > enable
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (load) begin
      value <= load_data;
    end else if (en) begin
      value <= up ? value + ONE : value - ONE;
    end
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - sequencing FSM for a loadable up/down counter with terminal-count detect
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             up_dn,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] term_q;
  logic             dir_q, rl_q;
  logic [WIDTH-1:0] target, init_val, reload_val, load_data;
  logic             at_target, clr, load, en, done_nx;

  // init_val uses the live inputs (start edge), reload_val the sampled config
  assign target     = (dir_q == DIR_UP) ? term_q : '0;
  assign at_target  = (count == target);
  assign init_val   = (up_dn == DIR_UP) ? '0 : term_val;
  assign reload_val = (dir_q == DIR_UP) ? '0 : term_q;

  always_comb begin
    state_nx  = state;
    clr       = 1'b0;
    load      = 1'b0;
    load_data = load_val;
    en        = 1'b0;
    done_nx   = 1'b0;
    if (stop) begin
      clr      = 1'b1;
      state_nx = S_IDLE;
    end else if (start) begin
      load      = 1'b1;
      load_data = init_val;
      state_nx  = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (at_target) begin
            done_nx = 1'b1;
            if (rl_q) begin
              load      = 1'b1;
              load_data = reload_val;
            end else begin
              state_nx = S_DONE;
            end
          end else if (pause) begin
            state_nx = S_HOLD;
          end else begin
            en = 1'b1;
          end
        end
        S_HOLD: begin
          if (load_en) begin
            load = 1'b1;
          end else if (!pause) begin
            state_nx = S_RUN;
          end
        end
        default: begin
          if (load_en) begin
            load = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      term_q <= '0;
      dir_q  <= 1'b0;
      rl_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_RUN) || (state_nx == S_HOLD);
      done  <= done_nx;
      if (start && !stop) begin
        term_q <= term_val;
        dir_q  <= up_dn;
        rl_q   <= auto_reload;
      end
    end
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .load      (load),
    .load_data (load_data),
    .en        (en),
    .up        (dir_q),
    .value     (count)
  );

endmodule
